knight_anim_sequencer: RTL

//   Sequences the knight walk-cycle sprite ROMs: selects which animation frame ROM is active,

---
 rtl/knight_anim_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/knight_anim_sequencer.sv
// Knight walk-cycle sequencer: animation frame select/facing FSM plus mirrored sprite ROM address generation.
// Optional build macro KNIGHT_ANIM_PAUSE_EN adds a 'pause' input that freezes the animation state.
module knight_anim_sequencer #(
  parameter int SPR_W       = 50,
  parameter int SPR_H       = 64,
  parameter int ADDR_W      = 12,
  parameter int WALK_FRAMES = 4,
  parameter int HOLD_TICKS  = 6,
  parameter int TICK_W      = $clog2(HOLD_TICKS + 1)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              move_left,
  input  logic              move_right,
`ifdef KNIGHT_ANIM_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [9:0]        knight_x,
  input  logic [9:0]        knight_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [2:0]        frame_sel,
  output logic              facing_left,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_hit,
  output logic              o_dbg_state,
  output logic [TICK_W-1:0] o_dbg_tick
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [2:0]          r_frame_sel;
  logic                r_facing_left;
  logic [ADDR_W-1:0]   r_rom_address;
  logic                r_sprite_hit;

  logic                w_dir_req;
  logic                w_adv;
  logic [10:0]         w_rel_x;
  logic [10:0]         w_rel_y;
  logic                w_hit;
  logic [10:0]         w_col;
  logic [ADDR_W-1:0]   w_row_base;
  logic [ADDR_W-1:0]   w_addr;

  assign w_dir_req = move_left ^ move_right;

`ifdef KNIGHT_ANIM_PAUSE_EN
  assign w_adv = frame_start & ~pause;
`else
  assign w_adv = frame_start;
`endif

  // Animation state moves only on video-frame boundaries, so the pose never tears mid-frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_frame_sel   <= 3'd0;
      r_facing_left <= 1'b0;
    end else if (w_adv) begin
      case (r_state)
        S_IDLE: begin
          if (w_dir_req) begin
            r_state       <= S_WALK;
            r_frame_sel   <= 3'd1;
            r_tick        <= '0;
            r_facing_left <= move_left;
          end else begin
            r_frame_sel   <= 3'd0;
          end
        end
        S_WALK: begin
          if (!w_dir_req) begin
            r_state     <= S_IDLE;
            r_frame_sel <= 3'd0;
            r_tick      <= '0;
          end else begin
            r_facing_left <= move_left;
            if (r_tick == TICK_W'(HOLD_TICKS - 1)) begin
              r_tick <= '0;
              // Walk cycle wraps back to frame 1; frame 0 is reserved for the idle pose.
              if (r_frame_sel == 3'(WALK_FRAMES))
                r_frame_sel <= 3'd1;
              else
                r_frame_sel <= r_frame_sel + 3'd1;
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_frame_sel <= 3'd0;
          r_tick      <= '0;
        end
      endcase
    end
  end

  // Unsigned 11-bit offsets: pixels left of / above the sprite wrap to large values and miss.
  assign w_rel_x    = {1'b0, DrawX} - {1'b0, knight_x};
  assign w_rel_y    = {1'b0, DrawY} - {1'b0, knight_y};
  assign w_hit      = (w_rel_x < 11'(SPR_W)) && (w_rel_y < 11'(SPR_H));
  assign w_col      = r_facing_left ? (11'(SPR_W - 1) - w_rel_x) : w_rel_x;
  assign w_row_base = ADDR_W'(w_rel_y) * ADDR_W'(SPR_W);
  assign w_addr     = w_hit ? (w_row_base + ADDR_W'(w_col)) : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_sprite_hit  <= 1'b0;
    end else begin
      r_rom_address <= w_addr;
      r_sprite_hit  <= w_hit;
    end
  end

  assign frame_sel   = r_frame_sel;
  assign facing_left = r_facing_left;
  assign rom_address = r_rom_address;
  assign sprite_hit  = r_sprite_hit;
  assign o_dbg_state = r_state;
  assign o_dbg_tick  = r_tick;

endmodule
